// File: rtl/my_mux_pkg.sv
// my_mux_pkg
//   Shared definitions for the round-robin N-way mux slice.
//   - mux_mode_e : selection mode encoding driven on the mux 'mode' input
//   - STAT_W     : width of each optional per-channel grant counter
//   - clog2_min1 : index width helper that never returns 0
package my_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  localparam int STAT_W = 16;

  // Index width for n items, at least one bit so N=1 still gets a real port.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/my_rr_arbiter_n.sv
// my_rr_arbiter_n
//   Combinational rotate-priority arbiter. The search starts at last+1 and
//   wraps at N, so the channel granted most recently has lowest priority.
// Ports:
//   req       [N]    request vector
//   last      [SELW] index granted most recently (0..N-1)
//   gnt_valid        some request was found
//   gnt_idx   [SELW] winning index (0 when gnt_valid=0)
module my_rr_arbiter_n
  import my_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  // Walk the N candidates in rotated order and keep the first requester.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = {SELW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(cand);
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/my_mux_rr_n_way.sv
// my_mux_rr_n_way
//   Registered N-way mux with valid/ready on every input and on the output.
//   mode=0 picks channel 'sel'; mode=1 shares the output round-robin.
//   One output register stage; full throughput (loads while draining).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data  [N*WIDTH]    channel i at [i*WIDTH +: WIDTH]
//   in_valid [N]          channel i offers a word
//   in_ready [N]          channel i word taken this cycle (one-hot or zero)
//   mode                  0 fixed select, 1 round-robin
//   sel      [SELW]       fixed-mode channel; values >= N select nothing
//   out_data [WIDTH]      registered word
//   out_valid             out_data holds a word
//   out_sel  [SELW]       source channel of out_data
//   out_ready             consumer accepts out_data
//   grant_cnt [N*16]      only with MY_MUX_RR_STATS_EN: saturating per-channel
//                         transfer counters at [i*16 +: 16]
module my_mux_rr_n_way
  import my_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
`ifdef MY_MUX_RR_STATS_EN
  ,
  output logic [N*STAT_W-1:0] grant_cnt
`endif
);

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SELW-1:0]  out_sel_r;
  logic [SELW-1:0]  rr_last_r;

  logic             rr_valid_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             fix_valid_s;
  logic             gnt_valid_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             can_load_s;
  logic             xfer_s;
  logic [WIDTH-1:0] gnt_data_s;

  my_rr_arbiter_n #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .last      (rr_last_r),
    .gnt_valid (rr_valid_s),
    .gnt_idx   (rr_idx_s)
  );

  // Fixed-mode request: out-of-range sel values grant nothing.
  always_comb begin
    fix_valid_s = 1'b0;
    if (int'(sel) < N) begin
      fix_valid_s = in_valid[sel];
    end else begin
      fix_valid_s = 1'b0;
    end
  end

  // Pick the grant source for the current mode.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = {SELW{1'b0}};
    if (mode == MODE_RR) begin
      gnt_valid_s = rr_valid_s;
      gnt_idx_s   = rr_idx_s;
    end else begin
      gnt_valid_s = fix_valid_s;
      gnt_idx_s   = sel;
    end
  end

  // Output slot is free if empty or being drained this cycle; rst_n gating
  // keeps in_ready low throughout reset.
  assign can_load_s = !out_valid_r || out_ready;
  assign xfer_s     = gnt_valid_s && can_load_s && rst_n;

  // Word of the granted channel.
  always_comb begin
    gnt_data_s = {WIDTH{1'b0}};
    if (gnt_valid_s) begin
      gnt_data_s = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
    end else begin
      gnt_data_s = {WIDTH{1'b0}};
    end
  end

  // One-hot ready back to the granted channel.
  always_comb begin
    in_ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (xfer_s && (gnt_idx_s == SELW'(i))) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Output register: load on transfer, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SELW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= gnt_data_s;
      out_sel_r   <= gnt_idx_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer; reset to N-1 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= SELW'(N - 1);
    end else if (xfer_s && (mode == MODE_RR)) begin
      rr_last_r <= gnt_idx_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;

`ifdef MY_MUX_RR_STATS_EN
  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [STAT_W-1:0] cnt_r;

    // Saturating count of transfers taken from channel g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= {STAT_W{1'b0}};
      end else if (xfer_s && (gnt_idx_s == SELW'(g)) && (cnt_r != {STAT_W{1'b1}})) begin
        cnt_r <= cnt_r + STAT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign grant_cnt[g*STAT_W +: STAT_W] = cnt_r;
  end
`endif

endmodule

// File: tb/tb_my_mux_rr_n_way.sv
// Directed self-checking bench for my_mux_rr_n_way (N=4/WIDTH=16 main
// instance plus an N=3/WIDTH=8 instance for out-of-range sel values).
module tb_my_mux_rr_n_way;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_sel3;

`ifdef MY_MUX_RR_STATS_EN
  logic [63:0] grant_cnt;
  logic [47:0] grant_cnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] words [4];

  always #5 clk = ~clk;

  my_mux_rr_n_way #(.WIDTH(16), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MY_MUX_RR_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  my_mux_rr_n_way #(.WIDTH(8), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (1'b0),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_sel   (out_sel3),
    .out_ready (1'b1)
`ifdef MY_MUX_RR_STATS_EN
    ,
    .grant_cnt (grant_cnt3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_tests++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
    n_tests++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_tests++;
      if (in_ready !== (4'b0001 << s)) begin n_fail++; $display("FAIL fixed_in_ready[%0d] got %b want %b", s, in_ready, 4'b0001 << s); end
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== words[s] || out_sel !== 2'(s)) begin
        n_fail++;
        $display("FAIL fixed_out[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d", s, out_valid, out_data, out_sel, words[s], s);
      end
    end
  endtask

  task automatic test_rr_all();
    // Pointer untouched by fixed-mode transfers, so the sequence starts at 0.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== words[c % 4]) begin
        n_fail++;
        $display("FAIL rr_all[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h", c, out_valid, out_sel, out_data, c % 4, words[c % 4]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_s;
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_s = (c % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      n_tests++;
      if (in_ready !== (4'b0001 << exp_s)) begin n_fail++; $display("FAIL rr_sparse_ready[%0d] got %b want %b", c, in_ready, 4'b0001 << exp_s); end
      step();
      n_tests++;
      if (out_sel !== exp_s || out_data !== words[exp_s]) begin
        n_fail++;
        $display("FAIL rr_sparse_out[%0d] got s=%0d d=%h want s=%0d d=%h", c, out_sel, out_data, exp_s, words[exp_s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Pointer at 3: next load is channel 0.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sel = 2'(c);
      #1;
      n_tests++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0000", c, in_ready); end
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'h8000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%b s=%0d d=%h want v=1 s=0 d=8000", c, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL release_ready got %b want 0010", in_ready); end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 16'h0800) begin
      n_fail++;
      $display("FAIL release_load got v=%b s=%0d d=%h want v=1 s=1 d=0800", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_no_grant();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL nogrant_ready got %b want 0000", in_ready); end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || out_sel !== 2'd1 || out_data !== 16'h0800) begin
      n_fail++;
      $display("FAIL nogrant_drain got v=%b s=%0d d=%h want v=0 s=1 d=0800", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_sel_out_of_range();
    sel3 = 2'd3;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL n3_sel3 got ready=%b v=%b want ready=000 v=0", in_ready3, out_valid3);
    end
    step();
    n_tests++;
    if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL n3_sel3_out got v=%b want 0", out_valid3); end
    sel3 = 2'd2;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b100) begin n_fail++; $display("FAIL n3_sel2_ready got %b want 100", in_ready3); end
    step();
    n_tests++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h33 || out_sel3 !== 2'd2) begin
      n_fail++;
      $display("FAIL n3_sel2_out got v=%b d=%h s=%0d want v=1 d=33 s=2", out_valid3, out_data3, out_sel3);
    end
    sel3 = 2'd3;
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset got v=%b ready=%b want v=0 ready=0000", out_valid, in_ready);
    end
`ifdef MY_MUX_RR_STATS_EN
    n_tests++;
    if (grant_cnt !== 64'd0) begin n_fail++; $display("FAIL midreset_cnt got %h want 0", grant_cnt); end
`endif
    #2;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL postreset_ready got %b want 0001", in_ready); end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'h8000) begin
      n_fail++;
      $display("FAIL postreset_out got v=%b s=%0d d=%h want v=1 s=0 d=8000", out_valid, out_sel, out_data);
    end
`ifdef MY_MUX_RR_STATS_EN
    n_tests++;
    if (grant_cnt !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL postreset_cnt got %h want 1", grant_cnt); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    words[0] = 16'h8000; words[1] = 16'h0800; words[2] = 16'h0080; words[3] = 16'h0008;
    in_data   = {words[3], words[2], words[1], words[0]};
    in_valid  = 4'hF;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data3  = {8'h33, 8'h22, 8'h11};
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    rst_n     = 1'b0;

    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_back_to_back();
    test_no_grant();
    test_sel_out_of_range();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
